cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle control FSM that sequences the shared RV32I datapath: register file, ALU, PC register, instruction register (IR) and a single unified memory port. It walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB states, driving the enables and selects for that datapath. It handshakes with a variable-latency memory and traps on illegal opcodes. It also counts retired instructions.

## Interface
- `TIMEOUT_CYCLES`, default 255: memory-wait watchdog limit; only used with `SEQ_MEM_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `instr`  in  32  current IR contents, held by the datapath.
- `mem_ready`  in  1  memory completes the access this cycle; zero-wait allowed.
- `branch_cond`  in  1  comparator result for the BRANCH in IR, valid in EXECUTE.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  store when 1.
- `mem_addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `ir_write`  out  1  load IR from memory read data.
- `pc_write`  out  1  update PC.
- `pc_src`  out  1  PC source: 0 = PC+4, 1 = PC+imm (B/J target).
- `rf_write_enable`  out  1  register-file write of rd.
- `wb_sel`  out  2  writeback source: 00 ALU, 01 load data, 10 PC+4 (link), 11 U-immediate (LUI).
- `alu_src_b`  out  1  ALU B input: 0 = rs2, 1 = immediate.
- `alu_op`  out  3  ALU operation.
- `alu_sub`  out  1  subtract/arithmetic variant.
- `halted`  out  1  sticky trap indicator.
- `trap_cause`  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- `instret`  out  32  retired-instruction count.

## Operation
- State register encodings: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Reset state is FETCH.
- Control outputs are combinational from the state and `instr`. Every output is 0 while `reset` is high.
- Reset values: `instret`=0, `trap_cause`=00, `halted`=0.
- FETCH:
  - Outputs: `mem_req`=1, `mem_addr_sel`=0.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1 with `pc_src`=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - One cycle for register read.
  - Opcode in {OP_IMM 0010011, OP 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111} → EXECUTE.
  - Any other opcode → TRAP with cause 01.
- EXECUTE, by opcode:
  - OP_IMM: `alu_src_b`=1, `alu_op`=funct3, `alu_sub`=instr[30] only when funct3=101 → WB.
  - OP: `alu_src_b`=0, `alu_op`=funct3, `alu_sub`=instr[30] → WB.
  - LUI: → WB.
  - LOAD/STORE: `alu_src_b`=1, `alu_op`=000 (address add) → MEM.
  - BRANCH: `pc_write`=`branch_cond`, `pc_src`=1, retire → FETCH.
  - JAL: `pc_write`=1, `pc_src`=1, `rf_write_enable`=1, `wb_sel`=10, retire → FETCH.
  - Because PC already holds PC+4 after fetch, the datapath computes the target from the latched old PC.
- MEM:
  - Outputs: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(STORE), ALU inputs held as in EXECUTE.
  - On `mem_ready`: LOAD → WB; STORE retires → FETCH.
- WB:
  - `rf_write_enable`=1; `wb_sel` is 01 for LOAD, 11 for LUI, else 00.
  - Retire → FETCH.
- Retire: `instret` increments by 1 and wraps 0xFFFFFFFF → 0.
- TRAP:
  - Absorbing until reset; all strobes are 0; `halted`=1.
  - `trap_cause` is latched on entry and is not overwritten.
- rd=x0 writes are still issued; the register file ignores them.

## Timing
- `mem_ready` is sampled at the posedge when `mem_req`=1. The request is held until then, with `mem_addr_sel`/`mem_we` stable.
- Zero-wait cycle counts: ALU/LUI 4; LOAD 5; STORE 4; BRANCH/JAL 3. Each memory wait cycle adds 1.
- `instret` updates on the posedge that leaves the retiring state.
- Reset asserted mid-access drops `mem_req` immediately. The first FETCH request is issued the first cycle after deassertion.

## Configuration
- `SEQ_MEM_TIMEOUT_EN` defined:
  - A counter tracks consecutive cycles in FETCH/MEM with `mem_ready`=0. It clears on `mem_ready` and on any state change.
  - Reaching `TIMEOUT_CYCLES` → TRAP with `trap_cause`=10.
- Undefined: waits are unbounded, the counter is absent, and `trap_cause` is never 10.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants;
  - state encoding;
  - `wb_sel`, `pc_src` and `mem_addr_sel` encodings;
  - `trap_cause` codes.
- One sub-module, `mem_wait_watchdog` (counter plus compare), instantiated only under `SEQ_MEM_TIMEOUT_EN`.

## Test plan
- ADDI x1,x0,5 (0x00500093) with zero-wait memory → FETCH, DECODE, EXECUTE, WB. `rf_write_enable` is high only in cycle 4, with `alu_op`=000 and `alu_src_b`=1; `instret`=1.
- LW with `mem_ready` delayed 3 cycles in MEM → `mem_req` held 4 cycles with `mem_addr_sel`=1, `mem_we`=0; WB `wb_sel`=01; 8 cycles total.
- BEQ with `branch_cond`=0, then with 1 → `pc_write` is 0, then 1 (`pc_src`=1) in EXECUTE; 3 cycles each.
- Opcode 0x7F → TRAP after DECODE: `halted`=1, `trap_cause`=01, no further `mem_req`, `instret` frozen. Reset returns to FETCH with all outputs cleared.
- `SEQ_MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `mem_ready` held 0 in FETCH → TRAP after the 4th wait cycle, `trap_cause`=10.
- Reset pulsed mid-MEM of a STORE → `mem_req` drops the same cycle, `instret`=0, and a fetch restarts after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: opcodes, FSM states,
// datapath select codes and trap causes.
package cpu_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_e;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    localparam logic [1:0] WB_LUI  = 2'b11;

    localparam logic PC_SRC_PLUS4  = 1'b0;
    localparam logic PC_SRC_TARGET = 1'b1;

    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;

    localparam logic [1:0] TRAP_NONE        = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'b10;

    function automatic logic opcode_legal(input logic [6:0] opc);
        return (opc == OPC_OP_IMM) || (opc == OPC_OP) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_LUI) ||
               (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Memory-wait watchdog: down-counter reloaded whenever the wait streak breaks,
// flags expiry on the TIMEOUT_CYCLES-th consecutive wait cycle.
module mem_wait_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic restart,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        expired = waiting && (cnt_q == '0);
        if (restart || !waiting) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the shared RV32I datapath with retire counter.
// Define SEQ_MEM_TIMEOUT_EN to add the memory-wait watchdog trap.
//
// state   | meaning
// FETCH   | request IR from memory at PC, load IR and PC+4 on ready
// DECODE  | register read, legality check of the opcode
// EXECUTE | ALU op / address add; branches and JAL retire here
// MEM     | data access at ALU address; stores retire on ready
// WB      | register-file write of rd, retire
// TRAP    | absorbing halt until reset
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        rf_write_enable,
    output logic [1:0]  wb_sel,
    output logic        alu_src_b,
    output logic [2:0]  alu_op,
    output logic        alu_sub,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    logic [1:0]  trap_cause_q, trap_cause_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    logic        mem_timeout;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_src_b_c, alu_sub_c;
    logic [2:0] alu_op_c;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // ALU controls are a pure function of the opcode so MEM/WB can hold them.
    always_comb begin
        alu_src_b_c = 1'b0;
        alu_op_c    = 3'b000;
        alu_sub_c   = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                alu_src_b_c = 1'b1;
                alu_op_c    = funct3;
                alu_sub_c   = (funct3 == 3'b101) && instr[30];
            end
            OPC_OP: begin
                alu_op_c  = funct3;
                alu_sub_c = instr[30];
            end
            OPC_LOAD, OPC_STORE: alu_src_b_c = 1'b1;
            default: ;
        endcase
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    logic wdog_waiting, wdog_restart;

    assign wdog_waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign wdog_restart = (state_d != state_q);

    mem_wait_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .waiting(wdog_waiting),
        .restart(wdog_restart),
        .expired(mem_timeout)
    );
`else
    assign mem_timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        trap_cause_d    = trap_cause_q;
        retire          = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr_sel    = ADDR_SEL_PC;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_src          = PC_SRC_PLUS4;
        rf_write_enable = 1'b0;
        wb_sel          = WB_ALU;
        alu_src_b       = 1'b0;
        alu_op          = 3'b000;
        alu_sub         = 1'b0;
        halted          = 1'b0;
        trap_cause      = trap_cause_q;
        instret         = instret_q;

        case (state_q)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_SEL_PC;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_PLUS4;
                    state_d  = ST_DECODE;
                end else if (mem_timeout) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_MEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (opcode_legal(opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                alu_src_b = alu_src_b_c;
                alu_op    = alu_op_c;
                alu_sub   = alu_sub_c;
                case (opcode)
                    OPC_OP_IMM, OPC_OP, OPC_LUI: state_d = ST_WB;
                    OPC_LOAD, OPC_STORE:         state_d = ST_MEM;
                    OPC_BRANCH: begin
                        pc_write = branch_cond;
                        pc_src   = PC_SRC_TARGET;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    OPC_JAL: begin
                        pc_write        = 1'b1;
                        pc_src          = PC_SRC_TARGET;
                        rf_write_enable = 1'b1;
                        wb_sel          = WB_LINK;
                        retire          = 1'b1;
                        state_d         = ST_FETCH;
                    end
                    default: begin
                        state_d      = ST_TRAP;
                        trap_cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_SEL_ALU;
                mem_we       = (opcode == OPC_STORE);
                alu_src_b    = alu_src_b_c;
                alu_op       = alu_op_c;
                alu_sub      = alu_sub_c;
                if (mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (mem_timeout) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_MEM_TIMEOUT;
                end
            end
            ST_WB: begin
                rf_write_enable = 1'b1;
                alu_src_b       = alu_src_b_c;
                alu_op          = alu_op_c;
                alu_sub         = alu_sub_c;
                if (opcode == OPC_LOAD)     wb_sel = WB_LOAD;
                else if (opcode == OPC_LUI) wb_sel = WB_LUI;
                else                        wb_sel = WB_ALU;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: halted = 1'b1;
            default: state_d = ST_FETCH;
        endcase

        instret_d = instret_q + 32'(retire);

        // Outputs are forced low combinationally so a mid-access reset drops mem_req at once.
        if (reset) begin
            mem_req         = 1'b0;
            mem_we          = 1'b0;
            mem_addr_sel    = 1'b0;
            ir_write        = 1'b0;
            pc_write        = 1'b0;
            pc_src          = 1'b0;
            rf_write_enable = 1'b0;
            wb_sel          = 2'b00;
            alu_src_b       = 1'b0;
            alu_op          = 3'b000;
            alu_sub         = 1'b0;
            halted          = 1'b0;
            trap_cause      = TRAP_NONE;
            instret         = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            trap_cause_q <= TRAP_NONE;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            instret_q    <= instret_d;
        end
    end

endmodule
